// File: rtl/reorder_buffer_if.sv
// Issue / execute / retire bus of the reorder buffer. The master side is the
// pipeline (issue and CDB); the slave side is the reorder buffer itself.
interface reorder_buffer_if #(parameter int IDX_W = 3);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [4:0]       alloc_rd;
  logic [IDX_W-1:0] alloc_tag;
  logic             cdb_valid;
  logic [IDX_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_mispredict;
  logic [31:0]      cdb_target;
  logic             rob_write_enable;
  logic [4:0]       rob_write_index;
  logic [31:0]      rob_write_data;
  logic             flush;
  logic [31:0]      flush_target;
  logic [IDX_W:0]   count;
  logic             empty;

  modport master (
    output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
    input  alloc_ready, alloc_tag, rob_write_enable, rob_write_index, rob_write_data,
           flush, flush_target, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
    output alloc_ready, alloc_tag, rob_write_enable, rob_write_index, rob_write_data,
           flush, flush_target, count, empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at issue, completes from the CDB, and
// retires in program order as one-cycle register-file write pulses.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  localparam logic [0:0]     ARM  = 1'b0;
  localparam logic [0:0]     GAP  = 1'b1;
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mispredict;
    logic [31:0] target;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]     count_q, count_d;
  logic [0:0]         state_q, state_d;
  logic               we_q, we_d;
  logic [4:0]         widx_q, widx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               flush_q, flush_d;
  logic [31:0]        ftgt_q, ftgt_d;
  logic               alloc_fire, commit_fire;
  entry_t             head_ent;

  assign head_ent    = ent_q[head_q];
  assign alloc_fire  = bus.alloc_valid && (count_q != FULL);
  assign commit_fire = (state_q == ARM) && head_ent.valid && head_ent.ready;

  assign bus.alloc_ready      = (count_q != FULL);
  assign bus.alloc_tag        = tail_q;
  assign bus.count            = count_q;
  assign bus.empty            = (count_q == '0);
  assign bus.rob_write_enable = we_q;
  assign bus.rob_write_index  = widx_q;
  assign bus.rob_write_data   = wdata_q;
  assign bus.flush            = flush_q;
  assign bus.flush_target     = ftgt_q;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    we_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    flush_d = 1'b0;
    ftgt_d  = ftgt_q;
    count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);

    if (bus.cdb_valid && ent_q[bus.cdb_tag].valid) begin
      ent_d[bus.cdb_tag].ready      = 1'b1;
      ent_d[bus.cdb_tag].data       = bus.cdb_data;
      ent_d[bus.cdb_tag].mispredict = bus.cdb_mispredict;
      ent_d[bus.cdb_tag].target     = bus.cdb_target;
    end

    if (alloc_fire) begin
      ent_d[tail_q].valid      = 1'b1;
      ent_d[tail_q].ready      = 1'b0;
      ent_d[tail_q].rd         = bus.alloc_rd;
      ent_d[tail_q].mispredict = 1'b0;
      tail_d                   = tail_q + 1'b1;
    end

    case (state_q)
      ARM: begin
        // Commit decision uses pre-edge state, so a same-edge completion waits for the next ARM.
        if (commit_fire) begin
          we_d                 = (head_ent.rd != 5'd0);
          widx_d               = head_ent.rd;
          wdata_d              = head_ent.data;
          ent_d[head_q].valid  = 1'b0;
          ent_d[head_q].ready  = 1'b0;
          head_d               = head_q + 1'b1;
          state_d              = GAP;
          if (head_ent.mispredict) begin
            flush_d = 1'b1;
            ftgt_d  = head_ent.target;
            ent_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ARM;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      flush_q <= 1'b0;
      ftgt_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      flush_q <= flush_d;
      ftgt_q  <= ftgt_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a random run, all checked
// against an in-order queue model of the buffer.
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.IDX_W(IDX_W)) bus ();
  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [IDX_W-1:0] tag;
    logic [4:0]       rd;
    bit               ready;
    logic [31:0]      data;
    bit               misp;
    logic [31:0]      target;
  } ment_t;

  ment_t            mq[$];
  logic [IDX_W-1:0] tail_m;
  bit               last_ret;
  logic             exp_we, exp_flush;
  logic [4:0]       exp_idx;
  logic [31:0]      exp_data, exp_ft;
  int               n_chk = 0;
  int               n_bad = 0;

  task automatic idle();
    bus.alloc_valid    = 1'b0;
    bus.alloc_rd       = 5'd0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
    bus.cdb_mispredict = 1'b0;
    bus.cdb_target     = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (rst) begin
      mq.delete();
      tail_m = '0; last_ret = 0;
      exp_we = 0; exp_idx = '0; exp_data = '0; exp_flush = 0; exp_ft = '0;
    end else begin
      bit    ret;
      ment_t h;
      ret = !last_ret && mq.size() > 0 && mq[0].ready;
      if (ret) h = mq[0];
      if (bus.cdb_valid)
        foreach (mq[i])
          if (mq[i].tag == bus.cdb_tag) begin
            mq[i].ready = 1; mq[i].data = bus.cdb_data;
            mq[i].misp = bus.cdb_mispredict; mq[i].target = bus.cdb_target;
          end
      if (bus.alloc_valid && mq.size() < DEPTH) begin
        mq.push_back('{tag: tail_m, rd: bus.alloc_rd, ready: 0, data: '0, misp: 0, target: '0});
        tail_m = tail_m + 1'b1;
      end
      exp_flush = 0;
      if (ret) begin
        void'(mq.pop_front());
        exp_we = (h.rd != 0); exp_idx = h.rd; exp_data = h.data;
        if (h.misp) begin
          mq.delete(); tail_m = '0; exp_flush = 1; exp_ft = h.target;
        end
      end else exp_we = 0;
      last_ret = ret;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
    n_chk++; if ({bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data} !== 38'd0) begin
      n_bad++; $display("FAIL reset_write got=%b/%h/%h want 0", bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data); end
    n_chk++; if ({bus.flush, bus.flush_target} !== 33'd0) begin
      n_bad++; $display("FAIL reset_flush got=%b/%h want 0", bus.flush, bus.flush_target); end
    n_chk++; if ({bus.alloc_ready, bus.alloc_tag, bus.empty, bus.count} !== {1'b1, 3'd0, 1'b1, 4'd0}) begin
      n_bad++; $display("FAIL reset_state ready=%b tag=%0d empty=%b count=%0d want 1/0/1/0", bus.alloc_ready, bus.alloc_tag, bus.empty, bus.count); end
  endtask

  task automatic test_single();
    idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'd5; tick();
    n_chk++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL single_count1 got=%0d want 1", bus.count); end
    idle(); bus.cdb_valid = 1; bus.cdb_tag = 3'd0; bus.cdb_data = 32'h1234; tick();
    n_chk++; if (bus.rob_write_enable !== 1'b0) begin n_bad++; $display("FAIL single_early got=%b want 0", bus.rob_write_enable); end
    idle(); tick();
    n_chk++; if ({bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data} !== {1'b1, 5'd5, 32'h1234}) begin
      n_bad++; $display("FAIL single_write got=%b/%0d/%h want 1/5/00001234", bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data); end
    n_chk++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL single_count0 got=%0d want 0", bus.count); end
    tick();
    n_chk++; if (bus.rob_write_enable !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width got=%b want 0", bus.rob_write_enable); end
  endtask

  task automatic test_ooo();
    logic [IDX_W-1:0] t[3];
    logic [4:0]       ix[$];
    logic [31:0]      dx[$];
    bit               prev = 0;
    int               back = 0;
    for (int i = 0; i < 3; i++) begin
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(i + 1); t[i] = tail_m; tick();
    end
    for (int k = 0; k < 12; k++) begin
      idle();
      if (k < 3) begin
        bus.cdb_valid = 1;
        bus.cdb_tag   = (k == 0) ? t[2] : (k == 1) ? t[0] : t[1];
        bus.cdb_data  = (k == 0) ? 32'hA : (k == 1) ? 32'hB : 32'hC;
      end
      tick();
      if (bus.rob_write_enable) begin
        ix.push_back(bus.rob_write_index); dx.push_back(bus.rob_write_data);
        if (prev) back++;
      end
      prev = bus.rob_write_enable;
    end
    n_chk++; if (ix.size() != 3) begin n_bad++; $display("FAIL ooo_pulses got=%0d want 3", ix.size()); end
    else begin
      n_chk++; if ({ix[0], dx[0], ix[1], dx[1], ix[2], dx[2]} !== {5'd1, 32'hB, 5'd2, 32'hC, 5'd3, 32'hA}) begin
        n_bad++; $display("FAIL ooo_order got=%0d:%h %0d:%h %0d:%h want 1:b 2:c 3:a", ix[0], dx[0], ix[1], dx[1], ix[2], dx[2]); end
    end
    n_chk++; if (back != 0) begin n_bad++; $display("FAIL ooo_gap adjacent_high=%0d want 0", back); end
  endtask

  task automatic test_full();
    int pulses = 0;
    rst = 1; idle(); tick(); rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(i + 1); tick();
    end
    n_chk++; if ({bus.alloc_ready, bus.count} !== {1'b0, 4'd8}) begin
      n_bad++; $display("FAIL full_state ready=%b count=%0d want 0/8", bus.alloc_ready, bus.count); end
    idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'd31; tick();
    n_chk++; if ({bus.count, bus.alloc_tag} !== {4'd8, 3'd0}) begin
      n_bad++; $display("FAIL full_ninth count=%0d tag=%0d want 8/0", bus.count, bus.alloc_tag); end
    for (int k = 0; k < DEPTH + 24; k++) begin
      idle();
      if (k < DEPTH) begin bus.cdb_valid = 1; bus.cdb_tag = 3'(k); bus.cdb_data = 32'h100 + 32'(k); end
      tick();
      if (bus.rob_write_enable) pulses++;
    end
    n_chk++; if (pulses != DEPTH) begin n_bad++; $display("FAIL full_pulses got=%0d want 8", pulses); end
    n_chk++; if ({bus.count, bus.alloc_tag, bus.empty} !== {4'd0, 3'd0, 1'b1}) begin
      n_bad++; $display("FAIL full_drain count=%0d tag=%0d empty=%b want 0/0/1", bus.count, bus.alloc_tag, bus.empty); end
  endtask

  task automatic test_x0();
    logic [IDX_W-1:0] t;
    int pulses = 0;
    idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'd0; t = tail_m; tick();
    idle(); bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_data = 32'hDEAD; tick();
    for (int k = 0; k < 4; k++) begin
      idle(); tick(); if (bus.rob_write_enable) pulses++;
    end
    n_chk++; if ({pulses[3:0], bus.count} !== 8'd0) begin
      n_bad++; $display("FAIL x0_retire pulses=%0d count=%0d want 0/0", pulses, bus.count); end
  endtask

  task automatic test_mispredict();
    logic [4:0]  ix[$];
    logic [31:0] dx[$];
    int          nflush = 0;
    int          stray = 0;
    logic [31:0] ft = '0;
    rst = 1; idle(); tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(i + 1); tick();
    end
    for (int k = 0; k < 12; k++) begin
      idle();
      if (k == 0) begin bus.cdb_valid = 1; bus.cdb_tag = 3'd0; bus.cdb_data = 32'h11; end
      if (k == 1) begin
        bus.cdb_valid = 1; bus.cdb_tag = 3'd1; bus.cdb_data = 32'h22;
        bus.cdb_mispredict = 1; bus.cdb_target = 32'h400;
      end
      tick();
      if (bus.rob_write_enable) begin ix.push_back(bus.rob_write_index); dx.push_back(bus.rob_write_data); end
      if (bus.flush) begin nflush++; ft = bus.flush_target; end
    end
    n_chk++; if (ix.size() != 2) begin n_bad++; $display("FAIL misp_pulses got=%0d want 2", ix.size()); end
    else begin
      n_chk++; if ({ix[0], dx[0], ix[1], dx[1]} !== {5'd1, 32'h11, 5'd2, 32'h22}) begin
        n_bad++; $display("FAIL misp_order got=%0d:%h %0d:%h want 1:11 2:22", ix[0], dx[0], ix[1], dx[1]); end
    end
    n_chk++; if (nflush != 1 || ft !== 32'h400) begin
      n_bad++; $display("FAIL misp_flush cycles=%0d target=%h want 1/00000400", nflush, ft); end
    n_chk++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL misp_count got=%0d want 0", bus.count); end
    idle(); bus.cdb_valid = 1; bus.cdb_tag = 3'd2; bus.cdb_data = 32'h33; tick();
    for (int k = 0; k < 4; k++) begin idle(); tick(); if (bus.rob_write_enable) stray++; end
    n_chk++; if (stray != 0 || bus.count !== 4'd0) begin
      n_bad++; $display("FAIL misp_stale_cdb pulses=%0d count=%0d want 0/0", stray, bus.count); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(i + 7); tick();
    end
    idle(); bus.cdb_valid = 1; bus.cdb_tag = mq[0].tag; bus.cdb_data = 32'h55; tick();
    idle(); rst = 1; tick(); rst = 0;
    n_chk++; if ({bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data, bus.flush, bus.flush_target} !== 71'd0) begin
      n_bad++; $display("FAIL rstmid_outs we=%b idx=%0d data=%h flush=%b want all 0", bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data, bus.flush); end
    n_chk++; if ({bus.count, bus.alloc_tag, bus.alloc_ready, bus.empty} !== {4'd0, 3'd0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL rstmid_state count=%0d tag=%0d ready=%b empty=%b want 0/0/1/1", bus.count, bus.alloc_tag, bus.alloc_ready, bus.empty); end
    for (int k = 0; k < 4; k++) begin idle(); tick(); if (bus.rob_write_enable) stray++; end
    n_chk++; if (stray != 0) begin n_bad++; $display("FAIL rstmid_pulse got=%0d want 0", stray); end
  endtask

  task automatic test_random();
    rst = 1; idle(); tick(); rst = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] ecnt;
      idle();
      rst = ($urandom_range(0, 199) == 0);
      bus.alloc_valid = ($urandom_range(0, 3) != 0);
      bus.alloc_rd    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) != 0) begin
        bus.cdb_valid      = 1;
        bus.cdb_tag        = (mq.size() > 0 && $urandom_range(0, 4) != 0) ?
                             mq[$urandom_range(0, mq.size() - 1)].tag : 3'($urandom_range(0, 7));
        bus.cdb_data       = $urandom;
        bus.cdb_mispredict = ($urandom_range(0, 19) == 0);
        bus.cdb_target     = $urandom;
      end
      tick();
      rst = 0;
      ecnt = 4'(mq.size());
      n_chk++;
      if ({bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data, bus.flush, bus.flush_target} !==
          {exp_we, exp_idx, exp_data, exp_flush, exp_ft}) begin
        n_bad++;
        $display("FAIL rand_commit cyc=%0d got=%b/%0d/%h/%b/%h want %b/%0d/%h/%b/%h", c,
                 bus.rob_write_enable, bus.rob_write_index, bus.rob_write_data, bus.flush, bus.flush_target,
                 exp_we, exp_idx, exp_data, exp_flush, exp_ft);
      end
      n_chk++;
      if ({bus.count, bus.empty, bus.alloc_ready, bus.alloc_tag} !== {ecnt, ecnt == 4'd0, ecnt < 4'd8, tail_m}) begin
        n_bad++;
        $display("FAIL rand_state cyc=%0d got count=%0d empty=%b ready=%b tag=%0d want %0d/%b/%b/%0d", c,
                 bus.count, bus.empty, bus.alloc_ready, bus.alloc_tag, ecnt, ecnt == 4'd0, ecnt < 4'd8, tail_m);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_ooo();
    test_full();
    test_x0();
    test_mispredict();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
